fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage feeding the dual-slot decode stage: drives the 64-bit instruction memory,
//  presents {pc, inst} bundles, honours decode interlock and one-cycle branch redirects.
//  Run/halt FSM: main core starts at reset, subcores start from a fetch address; an End in the
//  upper slot halts fetch. Opcodes Nop/End come from inst_package.
// PARAMETERS
//  ADDR_W      15  imem word-address width; one word is one 64-bit bundle
//  RESET_PC    0   fetch address used by AUTO_START
//  AUTO_START  1   1: enter RUN at RESET_PC after reset (main core); 0: wait in IDLE for start (subcore)
// PORTS
//  clk           in   1       clock
//  rstn          in   1       synchronous, active-low reset
//  start         in   1       pulse: begin fetching at start_pc; honoured only in IDLE/HALT
//  start_pc      in   32      start address (from decode fetch_addr)
//  interlock     in   1       decode stall: hold the presented bundle
//  branch_flag   in   1       registered one-cycle redirect from decode
//  branch_pc     in   32      redirect target, valid with branch_flag
//  imem_addr     out  ADDR_W  imem read address, registered (fetch_pc[ADDR_W-1:0])
//  imem_rdata    in   64      imem data; 1-cycle latency after imem_addr
//  pc            out  32      address of the presented bundle
//  inst          out  64      presented bundle; {Nop,26'b0,Nop,26'b0} when not valid
//  busy          out  1       1 in RUN
//  done          out  1       1 in HALT; cleared by start
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=0, imem_addr=0, pc=0, out_valid=0 (inst=Nop bundle), skid_valid=0,
//   busy=0, done=0. If AUTO_START, the first cycle after reset loads fetch_pc=RESET_PC and enters RUN.
//  Words are bundle-addressed: the sequential successor is pc+1.
//  inst = out_valid ? (skid_valid ? skid : imem_rdata) : Nop bundle; pc = out_pc (0 while invalid).
//  FSM: IDLE -start-> RUN -accepted End-> HALT -start-> RUN. start in RUN is ignored.
//   start: fetch_pc<=start_pc, done<=0, out_valid<=0; first bundle valid 2 cycles later.
//  RUN, no branch, no interlock: out_pc<=fetch_pc, out_valid<=1, fetch_pc<=fetch_pc+1,
//   skid_valid<=0. Throughput is 1 bundle/cycle.
//  Interlock: fetch_pc and out_pc hold. On the first interlocked cycle with out_valid, capture
//   imem_rdata into skid, skid_valid<=1. inst stays stable for every interlocked cycle and the
//   release cycle. After release, normal advance resumes; imem_addr was held, so rdata matches.
//  branch_flag (priority over interlock/End/advance): fetch_pc<=branch_pc, out_valid<=0,
//   skid_valid<=0. Next cycle: Nop bundle; following cycle: pc=branch_pc with its bundle.
//  Accepted End: out_valid & inst[63:58]==End & ~interlock & ~branch_flag -> HALT, out_valid<=0,
//   fetch_pc holds, busy<=0, done<=1. An End shown during branch_flag is squashed (no halt).
//   An End shown while interlocked halts only on the release cycle.
//  Wrap: fetch_pc is 32-bit and wraps at 2^32; imem_addr takes the low ADDR_W bits (aliasing).
//  Reset mid-operation returns every register to its reset value in one cycle; in-flight data is
//   dropped.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_bundles, perf_redirects, perf_stalls (32 bits each,
//   wrapping, reset 0, cleared on start). They count accepted valid bundles, branch_flag cycles
//   and interlocked cycles in RUN.
//  FETCH_PERF_CNT_EN undefined: no counters and no perf ports; all other behaviour is identical.
// TESTING
//  1 AUTO_START=1, imem[k]={k,k}: after reset, pc 0,1,2,3 on consecutive cycles, inst=imem[pc].
//  2 interlock high 3 cycles while pc=5 -> pc=5 and inst=imem[5] for 4 cycles, then pc 6,7.
//  3 branch_flag with branch_pc=0x40 while pc=9 -> one Nop-bundle cycle, then pc=0x40,0x41.
//  4 End at imem[3]: halts after pc=3 accepted, done=1, busy=0, Nop bundles; start with
//    start_pc=0x10 -> done=0, pc=0x10 two cycles later.
//  5 End at imem[7] shown during a branch_flag cycle -> no halt, target stream continues;
//    rstn low mid-run -> all outputs at reset values next cycle.
//  6 FETCH_PERF_CNT_EN on, scenarios 2+3 -> perf_stalls=3, perf_redirects=1.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage for the dual-slot decode stage. It drives a 64-bit
//   instruction memory with a registered word address and presents {pc, inst}
//   bundles. It holds a bundle while decode asserts interlock and takes one-cycle
//   branch redirects. A run/halt FSM starts fetching automatically after reset
//   on the main core (AUTO_START=1), or on a start pulse on subcores. An End
//   opcode in the upper slot of an accepted bundle halts fetch.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   start, start_pc    start pulse and fetch address (honoured in IDLE/HALT only)
//   interlock          decode stall: hold the presented bundle
//   branch_flag/pc     one-cycle redirect and its target
//   imem_addr          registered imem word address (low ADDR_W bits of fetch pc)
//   imem_rdata         imem read data, one cycle after imem_addr
//   pc, inst           presented bundle address and data (0 / Nop bundle when idle)
//   busy, done         1 in RUN / 1 in HALT
//
// Optional feature: macro FETCH_PERF_CNT_EN adds the 32-bit wrapping counters
//   perf_bundles, perf_redirects and perf_stalls. They are cleared by reset and
//   by a start that is honoured.
//
// Opcodes: Nop = 6'h00, End = 6'h3F. These are the inst_package values and are
//   kept local so that this file stands alone.

module fetch_unit #(
  parameter int          ADDR_W     = 15,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [31:0]       start_pc,
  input  logic              interlock,
  input  logic              branch_flag,
  input  logic [31:0]       branch_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [63:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [63:0]       inst,
  output logic              busy,
  output logic              done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_bundles,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_stalls
`endif
);

  localparam logic [5:0]  OP_NOP     = 6'h00;
  localparam logic [5:0]  OP_END     = 6'h3F;
  localparam logic [63:0] NOP_BUNDLE = {OP_NOP, 26'b0, OP_NOP, 26'b0};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [31:0] fetch_pc_p0, fetch_pc_nxt;
  logic [31:0] out_pc_p1, out_pc_nxt;
  logic        vld_p1, vld_nxt;
  logic [63:0] skid_p1;
  logic        skid_vld_p1, skid_vld_nxt;
  logic        skid_load;
  logic        launch, accept, end_seen;

  always_comb begin
    launch   = ((state == ST_IDLE) && (start || AUTO_START)) ||
               ((state == ST_HALT) && start);
    accept   = (state == ST_RUN) && vld_p1 && !interlock && !branch_flag;
    end_seen = vld_p1 && (inst[63:58] == OP_END);

    state_nxt    = state;
    fetch_pc_nxt = fetch_pc_p0;
    out_pc_nxt   = out_pc_p1;
    vld_nxt      = vld_p1;
    skid_vld_nxt = skid_vld_p1;
    skid_load    = 1'b0;

    case (state)
      ST_IDLE, ST_HALT: begin
        if (launch) begin
          state_nxt    = ST_RUN;
          fetch_pc_nxt = start ? start_pc : RESET_PC;
          vld_nxt      = 1'b0;
          skid_vld_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (branch_flag) begin
          fetch_pc_nxt = branch_pc;
          vld_nxt      = 1'b0;
          skid_vld_nxt = 1'b0;
        end else if (interlock) begin
          // imem_addr already points past the held bundle, so its data must
          // be parked in the skid before the next read overwrites it.
          if (vld_p1 && !skid_vld_p1) begin
            skid_load    = 1'b1;
            skid_vld_nxt = 1'b1;
          end
        end else if (end_seen) begin
          state_nxt    = ST_HALT;
          vld_nxt      = 1'b0;
          skid_vld_nxt = 1'b0;
        end else begin
          out_pc_nxt   = fetch_pc_p0;
          vld_nxt      = 1'b1;
          fetch_pc_nxt = fetch_pc_p0 + 32'd1;
          skid_vld_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0: fetch address / imem request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      fetch_pc_p0 <= 32'd0;
      imem_addr   <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc_p0 <= fetch_pc_nxt;
      imem_addr   <= fetch_pc_nxt[ADDR_W-1:0];
      vld_p1      <= vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      busy        <= (state_nxt == ST_RUN);
      done        <= (state_nxt == ST_HALT);
    end
  end

  // p1: presented bundle (data registers carry no reset; outputs are gated by vld_p1)
  always_ff @(posedge clk) begin
    out_pc_p1 <= out_pc_nxt;
    if (skid_load) skid_p1 <= imem_rdata;
  end

  assign pc   = vld_p1 ? out_pc_p1 : 32'd0;
  assign inst = vld_p1 ? (skid_vld_p1 ? skid_p1 : imem_rdata) : NOP_BUNDLE;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn || launch) begin
      perf_bundles   <= 32'd0;
      perf_redirects <= 32'd0;
      perf_stalls    <= 32'd0;
    end else if (state == ST_RUN) begin
      if (accept)      perf_bundles   <= perf_bundles + 32'd1;
      if (branch_flag) perf_redirects <= perf_redirects + 32'd1;
      if (interlock)   perf_stalls    <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. A synchronous memory model holds imem[k]={k,k},
// with End bundles placed at chosen words. Stimulus pushes the expected
// per-cycle outputs into a queue. A monitor pops and compares them on the
// falling edge.
module tb_fetch_unit;

  localparam logic [63:0] NOP = 64'h0;

  logic        clk = 1'b0;
  logic        rstn, start, interlock, branch_flag;
  logic [31:0] start_pc, branch_pc;
  logic [14:0] imem_addr;
  logic [63:0] imem_rdata = 64'h0;
  logic [31:0] pc;
  logic [63:0] inst;
  logic        busy, done;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bundles, perf_redirects, perf_stalls;
`endif

  fetch_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .start_pc(start_pc),
    .interlock(interlock), .branch_flag(branch_flag), .branch_pc(branch_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .busy(busy), .done(done)
`ifdef FETCH_PERF_CNT_EN
    , .perf_bundles(perf_bundles), .perf_redirects(perf_redirects),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:32767];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [63:0] inst;
    logic        busy;
    logic        done;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;

  function automatic logic [63:0] bnd(input logic [31:0] k);
    return {k, k};
  endfunction

  function automatic logic [63:0] endb(input logic [31:0] k);
    return {6'h3F, k[25:0], k};
  endfunction

  // Monitor: compare every expectation that falls due in the current cycle.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL missed cyc=%0d: expectation never sampled", e.cyc);
      end else if (pc !== e.pc || inst !== e.inst || busy !== e.busy || done !== e.done) begin
        bad++;
        $display("FAIL bundle cyc=%0d: got pc=%h inst=%h busy=%b done=%b, want pc=%h inst=%h busy=%b done=%b",
                 cyc, pc, inst, busy, done, e.pc, e.inst, e.busy, e.done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] p, input logic [63:0] i,
                      input logic b, input logic d);
    exp_t e;
    e.cyc = cyc; e.pc = p; e.inst = i; e.busy = b; e.done = d;
    q.push_back(e);
    tick();
  endtask

  task automatic run_seq(input logic [31:0] from, input int n);
    for (int k = 0; k < n; k++) step(from + k, bnd(from + k), 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32768; k++) mem[k] = bnd(k);
    rstn = 1'b0; start = 1'b0; start_pc = 32'h0;
    interlock = 1'b0; branch_flag = 1'b0; branch_pc = 32'h0;

    // Reset state, then auto-start stream 0,1,2,...
    tick(); tick();
    step(32'h0, NOP, 1'b0, 1'b0);
    rstn = 1'b1;
    step(32'h0, NOP, 1'b0, 1'b0);
    step(32'h0, NOP, 1'b1, 1'b0);
    run_seq(32'h0, 5);

    // Interlock for three cycles on pc=5: pc 5 shown four times.
    interlock = 1'b1;
    for (int k = 0; k < 3; k++) step(32'h5, bnd(5), 1'b1, 1'b0);
    interlock = 1'b0;
    step(32'h5, bnd(5), 1'b1, 1'b0);
    run_seq(32'h6, 3);

    // Branch on pc=9 to 0x40.
    branch_flag = 1'b1; branch_pc = 32'h40;
    step(32'h9, bnd(9), 1'b1, 1'b0);
    branch_flag = 1'b0;
    step(32'h0, NOP, 1'b1, 1'b0);
    run_seq(32'h40, 3);

`ifdef FETCH_PERF_CNT_EN
    total++;
    if (perf_stalls !== 32'd3) begin
      bad++;
      $display("FAIL perf_stalls: got %0d want 3", perf_stalls);
    end
    total++;
    if (perf_redirects !== 32'd1) begin
      bad++;
      $display("FAIL perf_redirects: got %0d want 1", perf_redirects);
    end
`endif

    // Reset mid-run, End at word 3 halts, restart at 0x10.
    mem[3] = endb(3); mem[7] = endb(7); mem[32'h23] = endb(32'h23);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    step(32'h0, NOP, 1'b0, 1'b0);
    step(32'h0, NOP, 1'b1, 1'b0);
    run_seq(32'h0, 3);
    step(32'h3, endb(3), 1'b1, 1'b0);
    step(32'h0, NOP, 1'b0, 1'b1);
    start = 1'b1; start_pc = 32'h10;
    step(32'h0, NOP, 1'b0, 1'b1);
    start = 1'b0;
    step(32'h0, NOP, 1'b1, 1'b0);
    step(32'h10, bnd(32'h10), 1'b1, 1'b0);
    // A start pulse while running has no effect.
    start = 1'b1; start_pc = 32'h30;
    step(32'h11, bnd(32'h11), 1'b1, 1'b0);
    start = 1'b0;

    // Branch to 5; End at 7 shown during a branch is squashed.
    branch_flag = 1'b1; branch_pc = 32'h5;
    step(32'h12, bnd(32'h12), 1'b1, 1'b0);
    branch_flag = 1'b0;
    step(32'h0, NOP, 1'b1, 1'b0);
    run_seq(32'h5, 2);
    branch_flag = 1'b1; branch_pc = 32'h20;
    step(32'h7, endb(7), 1'b1, 1'b0);
    branch_flag = 1'b0;
    step(32'h0, NOP, 1'b1, 1'b0);
    run_seq(32'h20, 3);

    // End at 0x23 under interlock halts only on the release cycle.
    interlock = 1'b1;
    step(32'h23, endb(32'h23), 1'b1, 1'b0);
    step(32'h23, endb(32'h23), 1'b1, 1'b0);
    interlock = 1'b0;
    step(32'h23, endb(32'h23), 1'b1, 1'b0);
    step(32'h0, NOP, 1'b0, 1'b1);
    step(32'h0, NOP, 1'b0, 1'b1);

    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
